// File: rtl/register_file.sv
// rtl/register_file.sv - architectural register file with rename tags and ROB commit/lookup merge
// Optional RF_STAT_EN adds commit and flush counters.
module register_file #(
  parameter int ROBWD = 4,
  parameter int NREG  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             ID_rn_flag,
  input  logic [4:0]       ID_rn_rd,
  input  logic [31:0]      ID_rn_rob_id,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  output logic [ROBWD-1:0] RF_id1_cut,
  output logic [ROBWD-1:0] RF_id2_cut,
  input  logic             RF_id1_ready,
  input  logic             RF_id2_ready,
  input  logic [31:0]      RF_id1_val,
  input  logic [31:0]      RF_id2_val,
  output logic             RF_rs1_busy,
  output logic [31:0]      RF_rs1_val,
  output logic [31:0]      RF_rs1_rob_id,
  output logic             RF_rs2_busy,
  output logic [31:0]      RF_rs2_val,
  output logic [31:0]      RF_rs2_rob_id,
  input  logic             ROB_cmt_rf_flag,
  input  logic [4:0]       ROB_cmt_rf_rd,
  input  logic [31:0]      ROB_cmt_rf_rob_id,
  input  logic [31:0]      ROB_cmt_rf_val,
  input  logic             jump_wrong_flag
`ifdef RF_STAT_EN
  ,
  output logic [31:0]      RF_cmt_cnt,
  output logic [31:0]      RF_flush_cnt
`endif
);

  logic [31:0]     val_q [NREG];
  logic [31:0]     tag_q [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  logic cmt_en;
  logic rn_en;
  logic flush_en;

  // x0 is excluded here so its row can never be written or renamed.
  assign cmt_en   = rdy & ROB_cmt_rf_flag & (ROB_cmt_rf_rd != 5'd0);
  assign flush_en = rdy & jump_wrong_flag;
  assign rn_en    = rdy & ID_rn_flag & (ID_rn_rd != 5'd0) & ~jump_wrong_flag;

  // Busy priority: matching commit clears, then flush clears all, else rename sets.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NREG; i++) begin
      if (cmt_en && (ROB_cmt_rf_rd == 5'(i)) && (tag_q[i] == ROB_cmt_rf_rob_id))
        busy_d[i] = 1'b0;
    end
    if (flush_en) begin
      busy_d = '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (rn_en && (ID_rn_rd == 5'(i)))
          busy_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (cmt_en && (ROB_cmt_rf_rd == 5'(i)))
          val_q[i] <= ROB_cmt_rf_val;
        if (rn_en && (ID_rn_rd == 5'(i)))
          tag_q[i] <= ID_rn_rob_id;
      end
      busy_q <= busy_d;
    end
  end

  logic [31:0] rs1_tag;
  logic [31:0] rs2_tag;

  assign rs1_tag    = tag_q[ID_rs1];
  assign rs2_tag    = tag_q[ID_rs2];
  assign RF_id1_cut = rs1_tag[ROBWD-1:0];
  assign RF_id2_cut = rs2_tag[ROBWD-1:0];

  // The commit bypass must win over the ROB lookup: that entry is being released this cycle.
  always_comb begin
    RF_rs1_busy   = 1'b0;
    RF_rs1_val    = '0;
    RF_rs1_rob_id = rs1_tag;
    if (ID_rs1 == 5'd0) begin
      RF_rs1_val = '0;
    end else if (!busy_q[ID_rs1]) begin
      RF_rs1_val = val_q[ID_rs1];
    end else if (ROB_cmt_rf_flag && (ROB_cmt_rf_rd == ID_rs1) &&
                 (ROB_cmt_rf_rob_id == rs1_tag)) begin
      RF_rs1_val = ROB_cmt_rf_val;
    end else if (RF_id1_ready) begin
      RF_rs1_val = RF_id1_val;
    end else begin
      RF_rs1_busy = 1'b1;
    end
  end

  always_comb begin
    RF_rs2_busy   = 1'b0;
    RF_rs2_val    = '0;
    RF_rs2_rob_id = rs2_tag;
    if (ID_rs2 == 5'd0) begin
      RF_rs2_val = '0;
    end else if (!busy_q[ID_rs2]) begin
      RF_rs2_val = val_q[ID_rs2];
    end else if (ROB_cmt_rf_flag && (ROB_cmt_rf_rd == ID_rs2) &&
                 (ROB_cmt_rf_rob_id == rs2_tag)) begin
      RF_rs2_val = ROB_cmt_rf_val;
    end else if (RF_id2_ready) begin
      RF_rs2_val = RF_id2_val;
    end else begin
      RF_rs2_busy = 1'b1;
    end
  end

`ifdef RF_STAT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RF_cmt_cnt   <= '0;
      RF_flush_cnt <= '0;
    end else begin
      if (cmt_en)
        RF_cmt_cnt <= RF_cmt_cnt + 32'd1;
      if (flush_en)
        RF_flush_cnt <= RF_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed bench for register_file with a reference model and per-cycle compare
module tb_register_file;
  localparam int ROBWD = 4;

  logic             clk;
  logic             rst;
  logic             rdy;
  logic             ID_rn_flag;
  logic [4:0]       ID_rn_rd;
  logic [31:0]      ID_rn_rob_id;
  logic [4:0]       ID_rs1;
  logic [4:0]       ID_rs2;
  logic [ROBWD-1:0] RF_id1_cut;
  logic [ROBWD-1:0] RF_id2_cut;
  logic             RF_id1_ready;
  logic             RF_id2_ready;
  logic [31:0]      RF_id1_val;
  logic [31:0]      RF_id2_val;
  logic             RF_rs1_busy;
  logic [31:0]      RF_rs1_val;
  logic [31:0]      RF_rs1_rob_id;
  logic             RF_rs2_busy;
  logic [31:0]      RF_rs2_val;
  logic [31:0]      RF_rs2_rob_id;
  logic             ROB_cmt_rf_flag;
  logic [4:0]       ROB_cmt_rf_rd;
  logic [31:0]      ROB_cmt_rf_rob_id;
  logic [31:0]      ROB_cmt_rf_val;
  logic             jump_wrong_flag;
`ifdef RF_STAT_EN
  logic [31:0]      RF_cmt_cnt;
  logic [31:0]      RF_flush_cnt;
`endif

  register_file #(.ROBWD(ROBWD), .NREG(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .ID_rn_flag(ID_rn_flag), .ID_rn_rd(ID_rn_rd), .ID_rn_rob_id(ID_rn_rob_id),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .RF_id1_cut(RF_id1_cut), .RF_id2_cut(RF_id2_cut),
    .RF_id1_ready(RF_id1_ready), .RF_id2_ready(RF_id2_ready),
    .RF_id1_val(RF_id1_val), .RF_id2_val(RF_id2_val),
    .RF_rs1_busy(RF_rs1_busy), .RF_rs1_val(RF_rs1_val), .RF_rs1_rob_id(RF_rs1_rob_id),
    .RF_rs2_busy(RF_rs2_busy), .RF_rs2_val(RF_rs2_val), .RF_rs2_rob_id(RF_rs2_rob_id),
    .ROB_cmt_rf_flag(ROB_cmt_rf_flag), .ROB_cmt_rf_rd(ROB_cmt_rf_rd),
    .ROB_cmt_rf_rob_id(ROB_cmt_rf_rob_id), .ROB_cmt_rf_val(ROB_cmt_rf_val),
    .jump_wrong_flag(jump_wrong_flag)
`ifdef RF_STAT_EN
    , .RF_cmt_cnt(RF_cmt_cnt), .RF_flush_cnt(RF_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic check_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, want);
    end
  endtask

  // Reference model: architectural state as plain arrays.
  logic [31:0] m_val  [32];
  logic [31:0] m_tag  [32];
  logic        m_busy [32];
  logic [31:0] m_cmt_cnt;
  logic [31:0] m_flush_cnt;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i]  <= 32'd0;
        m_tag[i]  <= 32'd0;
        m_busy[i] <= 1'b0;
      end
      m_cmt_cnt   <= 32'd0;
      m_flush_cnt <= 32'd0;
    end else if (rdy) begin
      if (ROB_cmt_rf_flag && ROB_cmt_rf_rd != 5'd0) begin
        m_val[ROB_cmt_rf_rd] <= ROB_cmt_rf_val;
        m_cmt_cnt <= m_cmt_cnt + 1;
        if (m_busy[ROB_cmt_rf_rd] && m_tag[ROB_cmt_rf_rd] == ROB_cmt_rf_rob_id)
          m_busy[ROB_cmt_rf_rd] <= 1'b0;
      end
      if (jump_wrong_flag) begin
        m_flush_cnt <= m_flush_cnt + 1;
        for (int i = 0; i < 32; i++) m_busy[i] <= 1'b0;
      end else if (ID_rn_flag && ID_rn_rd != 5'd0) begin
        m_busy[ID_rn_rd] <= 1'b1;
        m_tag[ID_rn_rd]  <= ID_rn_rob_id;
      end
    end
  end

  function automatic void model_query(input logic [4:0] r, input logic lk_rdy,
                                      input logic [31:0] lk_val, output logic eb,
                                      output logic [31:0] ev, output logic [31:0] eid);
    eb = 1'b0; ev = 32'd0; eid = m_tag[r];
    if (r == 5'd0) ev = 32'd0;
    else if (!m_busy[r]) ev = m_val[r];
    else if (ROB_cmt_rf_flag && ROB_cmt_rf_rd == r && ROB_cmt_rf_rob_id == m_tag[r]) ev = ROB_cmt_rf_val;
    else if (lk_rdy) ev = lk_val;
    else eb = 1'b1;
  endfunction

  logic        c_b;
  logic [31:0] c_v;
  logic [31:0] c_id;
  localparam logic [31:0] CUT_MASK = (32'd1 << ROBWD) - 32'd1;

  always @(negedge clk) begin
    if (check_en && rst) begin
      model_query(ID_rs1, RF_id1_ready, RF_id1_val, c_b, c_v, c_id);
      chk("cmp_rs1_busy", {31'd0, RF_rs1_busy}, {31'd0, c_b});
      if (c_b) begin
        chk("cmp_rs1_rob_id", RF_rs1_rob_id, c_id);
        chk("cmp_id1_cut", 32'(RF_id1_cut), c_id & CUT_MASK);
      end else begin
        chk("cmp_rs1_val", RF_rs1_val, c_v);
      end
      model_query(ID_rs2, RF_id2_ready, RF_id2_val, c_b, c_v, c_id);
      chk("cmp_rs2_busy", {31'd0, RF_rs2_busy}, {31'd0, c_b});
      if (c_b) begin
        chk("cmp_rs2_rob_id", RF_rs2_rob_id, c_id);
        chk("cmp_id2_cut", 32'(RF_id2_cut), c_id & CUT_MASK);
      end else begin
        chk("cmp_rs2_val", RF_rs2_val, c_v);
      end
`ifdef RF_STAT_EN
      chk("cmp_cmt_cnt", RF_cmt_cnt, m_cmt_cnt);
      chk("cmp_flush_cnt", RF_flush_cnt, m_flush_cnt);
`endif
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    ID_rn_flag = 1'b0;
    ROB_cmt_rf_flag = 1'b0;
    jump_wrong_flag = 1'b0;
    RF_id1_ready = 1'b0;
    RF_id2_ready = 1'b0;
  endtask

  task automatic rename(input logic [4:0] rd, input logic [31:0] id);
    ID_rn_flag = 1'b1; ID_rn_rd = rd; ID_rn_rob_id = id;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [31:0] id, input logic [31:0] v);
    ROB_cmt_rf_flag = 1'b1; ROB_cmt_rf_rd = rd; ROB_cmt_rf_rob_id = id; ROB_cmt_rf_val = v;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1;
    ID_rn_flag = 0; ID_rn_rd = 0; ID_rn_rob_id = 0; ID_rs1 = 5; ID_rs2 = 0;
    RF_id1_ready = 0; RF_id2_ready = 0; RF_id1_val = 32'hA5A5_0001; RF_id2_val = 32'hA5A5_0002;
    ROB_cmt_rf_flag = 0; ROB_cmt_rf_rd = 0; ROB_cmt_rf_rob_id = 0; ROB_cmt_rf_val = 0;
    jump_wrong_flag = 0;
    #1 rst = 1'b0;
    #2;
    chk("reset_busy", {31'd0, RF_rs1_busy}, 32'd0);
    chk("reset_val", RF_rs1_val, 32'd0);
    chk("reset_rob_id", RF_rs1_rob_id, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    check_en = 1'b1;

    commit(5, 0, 32'h55); adv();
    step(); chk("x5_written", RF_rs1_val, 32'h55);
    #1 rst = 1'b0;
    #1;
    chk("async_reset_busy", {31'd0, RF_rs1_busy}, 32'd0);
    chk("async_reset_val", RF_rs1_val, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    rename(5, 7); adv();
    step();
    chk("rn_busy", {31'd0, RF_rs1_busy}, 32'd1);
    chk("rn_rob_id", RF_rs1_rob_id, 32'd7);
    chk("rn_cut", 32'(RF_id1_cut), 32'd7);
    RF_id1_ready = 1'b1; RF_id1_val = 32'h1234;
    #1;
    chk("lookup_busy", {31'd0, RF_rs1_busy}, 32'd0);
    chk("lookup_val", RF_rs1_val, 32'h1234);
    adv();

    commit(5, 7, 32'hDEAD);
    step();
    chk("bypass_busy", {31'd0, RF_rs1_busy}, 32'd0);
    chk("bypass_val", RF_rs1_val, 32'hDEAD);
    adv(); step();
    chk("post_cmt_val", RF_rs1_val, 32'hDEAD);

    adv(); rename(5, 9); adv();
    commit(5, 7, 32'h11);
    step();
    chk("stale_cmt_busy", {31'd0, RF_rs1_busy}, 32'd1);
    chk("stale_cmt_id", RF_rs1_rob_id, 32'd9);
    adv(); step();
    chk("stale_kept_busy", {31'd0, RF_rs1_busy}, 32'd1);
    commit(5, 9, 32'h22);
    #1 chk("young_bypass", RF_rs1_val, 32'h22);
    adv(); step();
    chk("young_busy", {31'd0, RF_rs1_busy}, 32'd0);
    chk("young_val", RF_rs1_val, 32'h22);

    adv(); rename(8, 32'h20); adv();
    rename(8, 32'h21); commit(8, 32'h20, 32'h77); ID_rs2 = 8; adv();
    step();
    chk("rn_wins_busy", {31'd0, RF_rs2_busy}, 32'd1);
    chk("rn_wins_id", RF_rs2_rob_id, 32'h21);
    commit(8, 32'h21, 32'h88); adv();
    step(); chk("rn_wins_val", RF_rs2_val, 32'h88);

    adv(); rename(7, 32'h17); adv();
    commit(7, 32'h7, 32'h99); adv();
    ID_rs1 = 7; step();
    chk("wrap_busy", {31'd0, RF_rs1_busy}, 32'd1);
    chk("wrap_cut", 32'(RF_id1_cut), 32'd7);

    adv(); rdy = 1'b0; rename(9, 3); commit(9, 3, 32'h5); adv();
    rdy = 1'b1; ID_rs1 = 9; step();
    chk("hold_busy", {31'd0, RF_rs1_busy}, 32'd0);
    chk("hold_val", RF_rs1_val, 32'd0);

    adv(); rename(0, 1); commit(0, 1, 32'hFF); adv();
    ID_rs1 = 0; step();
    chk("x0_val", RF_rs1_val, 32'd0);

    adv(); rename(3, 4); adv(); rename(4, 5); adv();
    ID_rs1 = 3; ID_rs2 = 4; step();
    chk("pre_flush_b1", {31'd0, RF_rs1_busy}, 32'd1);
    chk("pre_flush_id2", RF_rs2_rob_id, 32'd5);
    adv();
    jump_wrong_flag = 1'b1; rename(6, 6); commit(4, 5, 32'h44); adv();
    jump_wrong_flag = 1'b1; rename(0, 8); adv();
    step();
    chk("flush_x3", {31'd0, RF_rs1_busy}, 32'd0);
    chk("flush_x4", {31'd0, RF_rs2_busy}, 32'd0);
    chk("flush_cmt_val", RF_rs2_val, 32'h44);
    adv(); ID_rs1 = 6; ID_rs2 = 0; step();
    chk("flush_x6", {31'd0, RF_rs1_busy}, 32'd0);
    chk("flush_x0", RF_rs2_val, 32'd0);
`ifdef RF_STAT_EN
    chk("stat_flush", RF_flush_cnt, 32'd2);
`endif
    adv(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
